// File: rtl/leg_solver.sv
// Other leg of a right triangle: b = floor(sqrt(c*c - a*a)), restoring root at one bit per cycle.
// Latency WIDTH+2 cycles (2 on a > c); start/busy/done handshake, start ignored while busy.
module leg_solver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b_out,
  output logic             exact,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROOT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   c_q, a_q;
  logic [2*WIDTH-1:0] diff;
  logic [WIDTH+1:0]   rem, rem_sh, rem_nxt, trial;
  logic [WIDTH-1:0]   root, root_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] c_sq, a_sq;
  logic               take;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  state_nxt = (a_q > c_q) ? S_DONE : S_ROOT;
      S_ROOT:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CALC) || (state == S_ROOT);
    done = (state == S_DONE);
  end

  assign c_sq = (2*WIDTH)'(c_q) * (2*WIDTH)'(c_q);
  assign a_sq = (2*WIDTH)'(a_q) * (2*WIDTH)'(a_q);

  // diff is shifted left each step, so its top two bits are always the next pair to bring down.
  always_comb begin
    rem_sh   = (rem << 2) | (WIDTH+2)'(diff[2*WIDTH-1 -: 2]);
    trial    = (WIDTH+2)'({root, 2'b01});
    take     = (rem_sh >= trial);
    rem_nxt  = take ? (rem_sh - trial) : rem_sh;
    root_nxt = (root << 1) | WIDTH'(take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      a_q   <= '0;
      diff  <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      b_out <= '0;
      exact <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            c_q   <= c_in;
            a_q   <= a_in;
            b_out <= '0;
            exact <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_CALC: begin
          diff <= c_sq - a_sq;
          rem  <= '0;
          root <= '0;
          cnt  <= CW'(WIDTH-1);
          if (a_q > c_q) err <= 1'b1;
        end
        S_ROOT: begin
          diff <= diff << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            b_out <= root_nxt;
            exact <= (rem_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leg_solver.sv
// Bench for leg_solver: timeline/arithmetic reference model for WIDTH=8 and WIDTH=4 instances,
// directed cases with literal expectations, then randomized back-to-back traffic.
module tb_leg_solver;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] c_in, a_in;
  wire  [1:0] bz, dn, ex, er;
  wire  [7:0] b8;
  wire  [3:0] b4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  leg_solver #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in), .a_in(a_in),
    .busy(bz[0]), .done(dn[0]), .b_out(b8), .exact(ex[0]), .err(er[0])
  );

  leg_solver #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in[3:0]), .a_in(a_in[3:0]),
    .busy(bz[1]), .done(dn[1]), .b_out(b4), .exact(ex[1]), .err(er[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int d);
    int r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  // Reference model: per instance, when a request was taken and what its result must be.
  int cyc = 0;
  int wd[2] = '{8, 4};
  bit act[2];
  int acc[2], dcy[2], eb[2], eex[2], eer[2], nops[2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 1'b0;
      end else if (start && (!act[i] || cyc - 1 >= dcy[i])) begin
        int m, c, a, d;
        m = (1 << wd[i]) - 1;
        c = int'(c_in) & m;
        a = int'(a_in) & m;
        act[i] = 1'b1;
        acc[i] = cyc;
        nops[i]++;
        if (a > c) begin
          eer[i] = 1; eb[i] = 0; eex[i] = 0;
          dcy[i] = cyc + 1;
        end else begin
          d = c * c - a * a;
          eb[i]  = isqrt(d);
          eex[i] = (eb[i] * eb[i] == d) ? 1 : 0;
          eer[i] = 0;
          dcy[i] = cyc + wd[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        int xb, xd, xv, xe, xr, bo;
        bo = (i == 0) ? int'(b8) : int'(b4);
        if (!act[i]) begin
          xb = 0; xd = 0; xv = 0; xe = 0; xr = 0;
        end else begin
          xb = (cyc >= acc[i] && cyc < dcy[i]) ? 1 : 0;
          xd = (cyc == dcy[i]) ? 1 : 0;
          xv = (cyc >= dcy[i]) ? eb[i] : 0;
          xe = (cyc >= dcy[i]) ? eex[i] : 0;
          xr = (cyc >= dcy[i]) ? eer[i] : 0;
        end
        chk($sformatf("w%0d_busy@%0d", wd[i], cyc), 32'(bz[i]), 32'(xb));
        chk($sformatf("w%0d_done@%0d", wd[i], cyc), 32'(dn[i]), 32'(xd));
        chk($sformatf("w%0d_b_out@%0d", wd[i], cyc), 32'(bo), 32'(xv));
        chk($sformatf("w%0d_exact@%0d", wd[i], cyc), 32'(ex[i]), 32'(xe));
        chk($sformatf("w%0d_err@%0d", wd[i], cyc), 32'(er[i]), 32'(xr));
      end
    end
  end

  // One request on the WIDTH=8 instance with literal expectations; optional mid-run start or reset.
  task automatic op(input string name, input logic [7:0] c, input logic [7:0] a,
                    input int xb, input int xe, input int xr, input int xlat,
                    input bit inj_start, input bit inj_rst);
    int lat, busy_n;
    bit got;
    lat = 0; busy_n = 0; got = 1'b0;
    @(negedge clk);
    c_in = c; a_in = a; start = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bz[0]) busy_n++;
      if (dn[0]) got = 1'b1;
      if (lat == 1) begin
        start = 1'b0;
        c_in = 8'($urandom);
        a_in = 8'($urandom);
      end
      if (inj_start && lat == 4) begin
        start = 1'b1; c_in = 8'd25; a_in = 8'd7;
      end
      if (inj_start && lat == 6) start = 1'b0;
      if (inj_rst && lat == 4) rst = 1'b1;
      if (inj_rst && lat == 5) begin
        chk({name, "_rst_busy"}, 32'(bz[0]), 0);
        chk({name, "_rst_done"}, 32'(dn[0]), 0);
        chk({name, "_rst_b_out"}, 32'(b8), 0);
        rst = 1'b0;
      end
    end
    if (inj_rst) begin
      chk({name, "_no_done"}, 32'(got), 0);
    end else begin
      chk({name, "_done_seen"}, 32'(got), 1);
      chk({name, "_latency"}, 32'(lat), 32'(xlat));
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'((xr != 0) ? 1 : 9));
      chk({name, "_b_out"}, 32'(b8), 32'(xb));
      chk({name, "_exact"}, 32'(ex[0]), 32'(xe));
      chk({name, "_err"}, 32'(er[0]), 32'(xr));
    end
  endtask

  initial begin
    int guard, pick, cv;
    rst = 1'b1; start = 1'b0; c_in = '0; a_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bz[0]), 0);
    chk("reset_done", 32'(dn[0]), 0);
    chk("reset_b_out", 32'(b8), 0);
    chk("reset_exact", 32'(ex[0]), 0);
    chk("reset_err", 32'(er[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    op("t1",      8'd5,   8'd3,  4,   1, 0, 10, 1'b0, 1'b0);
    op("t2a",     8'd25,  8'd7,  24,  1, 0, 10, 1'b0, 1'b0);
    op("t2b",     8'd10,  8'd6,  8,   1, 0, 10, 1'b0, 1'b0);
    op("t3a",     8'd15,  8'd10, 11,  0, 0, 10, 1'b0, 1'b0);
    op("t3b",     8'd255, 8'd0,  255, 1, 0, 10, 1'b0, 1'b0);
    op("t4a",     8'd3,   8'd4,  0,   0, 1, 2,  1'b0, 1'b0);
    op("t4b",     8'd0,   8'd0,  0,   1, 0, 10, 1'b0, 1'b0);
    op("a_eq_c",  8'd200, 8'd200, 0,  1, 0, 10, 1'b0, 1'b0);
    op("t5",      8'd5,   8'd3,  4,   1, 0, 10, 1'b1, 1'b0);
    op("t6",      8'd5,   8'd3,  0,   0, 0, 10, 1'b0, 1'b1);
    op("t6_next", 8'd10,  8'd8,  6,   1, 0, 10, 1'b0, 1'b0);

    // Random traffic: start mostly held high, so DONE->CALC restarts happen back to back.
    nops[0] = 0;
    guard = 0;
    while (nops[0] < 2000 && guard < 60000) begin
      @(negedge clk);
      guard++;
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) != 0);
      pick  = $urandom_range(0, 9);
      cv    = $urandom_range(0, 255);
      c_in  = 8'(cv);
      case (pick)
        0: a_in = 8'(cv);
        1: a_in = 8'd0;
        2: a_in = 8'($urandom);
        3: begin c_in = 8'd255; a_in = 8'($urandom_range(0, 3)); end
        default: a_in = 8'($urandom_range(0, cv));
      endcase
    end
    chk("random_ops_completed", 32'(nops[0] >= 2000), 1);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
